// File: rtl/mcp4725_pkg.sv
// Shared definitions for the MCP4725 I2C target and the DAC driver.
package mcp4725_pkg;

  // Default 7-bit target address. The write address byte is 8'hC2.
  localparam logic [6:0]  MCP4725_DEV_ADDR  = 7'b1100001;

  // Fast-mode write command: the top two bits of the high data byte.
  localparam logic [1:0]  CMD_FAST_WRITE    = 2'b00;

  // DAC code loaded at reset (mid-scale).
  localparam logic [11:0] MCP4725_MID_SCALE = 12'h800;

  // Number of data bits in one I2C byte.
  localparam logic [3:0]  BITS_PER_BYTE     = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_HI_BYTE,
    ST_HI_ACK,
    ST_LO_BYTE,
    ST_LO_ACK,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Brings raw SCL/SDA into the i_clk domain and flags SCL edges and
// START/STOP conditions, one cycle wide each.
module i2c_line_sync (
  input  logic i_clk,
  input  logic reset,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda_sync,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic r_scl_meta, r_scl_sync, r_scl_dly;
  logic r_sda_meta, r_sda_sync, r_sda_dly;

  // Two-flop synchronizers plus one delay stage for edge detection; an idle bus is high.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_dly  <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_sda_dly  <= 1'b1;
    end else begin
      r_scl_meta <= i_scl;
      r_scl_sync <= r_scl_meta;
      r_scl_dly  <= r_scl_sync;
      r_sda_meta <= i_sda;
      r_sda_sync <= r_sda_meta;
      r_sda_dly  <= r_sda_sync;
    end
  end

  assign o_sda_sync = r_sda_sync;
  assign o_scl_rise = r_scl_sync & ~r_scl_dly;
  assign o_scl_fall = ~r_scl_sync & r_scl_dly;
  // SDA may only move while SCL is high for a START or STOP, so SCL must be high on both samples.
  assign o_start    = r_scl_sync & r_scl_dly & r_sda_dly & ~r_sda_sync;
  assign o_stop     = r_scl_sync & r_scl_dly & ~r_sda_dly & r_sda_sync;

endmodule

// File: rtl/mcp4725_i2c_target.sv
// I2C write-only target emulating the MCP4725 fast-mode write command.
// It ACKs its own address and accepts repeated high/low byte pairs,
// committing a new DAC code after each complete pair.
module mcp4725_i2c_target
  import mcp4725_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR   = MCP4725_DEV_ADDR,
  parameter logic [11:0] RESET_CODE = MCP4725_MID_SCALE
) (
  input  logic        i_clk,
  input  logic        reset,
  input  logic        i_scl,
  input  logic        i_sda,
  output logic        o_sda_oe,
  output logic [11:0] o_dac_value,
  output logic [1:0]  o_pd,
  output logic        o_update,
  output logic        o_busy
);

  logic   w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic   w_byte_done;
  logic   w_is_byte_state;
  state_e r_state, w_next_state;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [5:0]  r_hi;
  logic [11:0] r_dac_value;
  logic [1:0]  r_pd;
  logic        r_update;

  i2c_line_sync u_line_sync (
    .i_clk      (i_clk),
    .reset      (reset),
    .i_scl      (i_scl),
    .i_sda      (i_sda),
    .o_sda_sync (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  // A byte ends on the SCL falling edge that closes its eighth bit.
  assign w_byte_done     = w_scl_fall && (r_bit_cnt == BITS_PER_BYTE);
  assign w_is_byte_state = (r_state == ST_ADDR) || (r_state == ST_HI_BYTE) ||
                           (r_state == ST_LO_BYTE);

  // State register.
  always_ff @(posedge i_clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic; STOP and START win over bit traffic in the same cycle.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    if (w_stop) begin
      w_next_state = ST_IDLE;
    end else if (w_start) begin
      w_next_state = ST_ADDR;
    end else begin
      unique case (r_state)
        ST_IDLE:     w_next_state = ST_IDLE;
        ST_ADDR:
          if (w_byte_done)
            w_next_state = (r_shift[7:1] == DEV_ADDR && !r_shift[0]) ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK: if (w_scl_fall) w_next_state = ST_HI_BYTE;
        ST_HI_BYTE:
          if (w_byte_done)
            w_next_state = (r_shift[7:6] == CMD_FAST_WRITE) ? ST_HI_ACK : ST_IGNORE;
        ST_HI_ACK:   if (w_scl_fall) w_next_state = ST_LO_BYTE;
        ST_LO_BYTE:  if (w_byte_done) w_next_state = ST_LO_ACK;
        ST_LO_ACK:   if (w_scl_fall) w_next_state = ST_HI_BYTE;
        ST_IGNORE:   w_next_state = ST_IGNORE;
        default:     w_next_state = ST_IDLE;
      endcase
    end
  end

  // Outputs: pull SDA only in ACK clocks, released the same cycle a START/STOP appears.
  always_comb begin
    o_sda_oe = 1'b0;
    o_busy   = (r_state != ST_IDLE);
    if ((r_state == ST_ADDR_ACK || r_state == ST_HI_ACK || r_state == ST_LO_ACK) &&
        !w_start && !w_stop)
      o_sda_oe = 1'b1;
  end

  // Bit counter and shift register: cleared at every byte boundary, saturating at eight bits.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_start || w_stop || (w_next_state != r_state)) begin
      r_bit_cnt <= '0;
    end else if (w_is_byte_state && w_scl_rise && (r_bit_cnt != BITS_PER_BYTE)) begin
      r_bit_cnt <= r_bit_cnt + 4'd1;
      r_shift   <= {r_shift[6:0], w_sda};
    end
  end

  // High byte is held while the low byte arrives; the pair commits at the end of the LO_ACK clock.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_hi        <= '0;
      r_dac_value <= RESET_CODE;
      r_pd        <= 2'b00;
      r_update    <= 1'b0;
    end else begin
      r_update <= 1'b0;
      if (r_state == ST_HI_BYTE && w_next_state == ST_HI_ACK)
        r_hi <= r_shift[5:0];
      if (r_state == ST_LO_ACK && w_next_state == ST_HI_BYTE) begin
        r_dac_value <= {r_hi[3:0], r_shift};
        r_pd        <= r_hi[5:4];
        r_update    <= 1'b1;
      end
    end
  end

  assign o_dac_value = r_dac_value;
  assign o_pd        = r_pd;
  assign o_update    = r_update;

endmodule

// File: doc/mcp4725_i2c_target.md
MCP4725_I2C_TARGET -- requirements
Module: mcp4725_i2c_target

Interface
REQ-001 Parameter DEV_ADDR, default 7'b1100001, the 7-bit target address (write address byte 8'hC2).
REQ-002 Parameter RESET_CODE, default 12'h800, the DAC code after reset (mid-scale).
REQ-003 i_clk  input  1  system clock; all logic on rising edge; SCL/SDA oversampled by it.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_scl  input  1  raw I2C SCL line, asynchronous to i_clk.
REQ-006 i_sda  input  1  raw I2C SDA line, asynchronous to i_clk.
REQ-007 o_sda_oe  output  1  1 = pull SDA low; 0 = release (pad is high-Z); never drives high.
REQ-008 o_dac_value  output  12  last committed DAC code.
REQ-009 o_pd  output  2  last committed power-down bits PD1:PD0.
REQ-010 o_update  output  1  one-cycle pulse when o_dac_value/o_pd are committed.
REQ-011 o_busy  output  1  high from START detection until STOP detection, regardless of address match.

Function
REQ-012 i_scl and i_sda SHALL each pass through a 2-flop synchronizer; all edge detection uses synchronized values delayed one further cycle.
REQ-013 START = synchronized SDA falling while SCL high; STOP = SDA rising while SCL high; both are checked before data sampling in the same cycle.
REQ-014 Data bits SHALL be sampled on synchronized SCL rising edges, MSB first; o_sda_oe changes only on synchronized SCL falling edges.
REQ-015 States: IDLE, ADDR, ADDR_ACK, HI_BYTE, HI_ACK, LO_BYTE, LO_ACK, IGNORE.
REQ-016 IDLE -> ADDR on START; bit counter cleared.
REQ-017 ADDR: after 8 bits, if addr[7:1]==DEV_ADDR and R/W==0 -> ADDR_ACK; otherwise -> IGNORE with SDA released (NACK).
REQ-018 xx_ACK states: o_sda_oe asserts on the SCL falling edge ending bit 8 and deasserts on the SCL falling edge ending the 9th (ACK) clock.
REQ-019 ADDR_ACK -> HI_BYTE; HI_BYTE after 8 bits: if bits[7:6]==2'b00 (fast-mode write) -> HI_ACK, holding PD=bits[5:4] and D11..D8=bits[3:0]; else -> IGNORE with NACK.
REQ-020 HI_ACK -> LO_BYTE; LO_BYTE after 8 bits -> LO_ACK holding D7..D0.
REQ-021 At the SCL falling edge ending the LO_ACK clock, o_dac_value and o_pd SHALL update and o_update SHALL pulse for exactly one i_clk cycle; the state then returns to HI_BYTE for a further fast-mode pair.
REQ-022 IGNORE: o_sda_oe=0 and no outputs change until START or STOP.
REQ-023 STOP in any state -> IDLE; any partially received pair is discarded with no update.
REQ-024 Repeated START in any state -> ADDR; partial data is discarded and o_busy stays high.
REQ-025 A START or STOP during an ACK clock SHALL release SDA in the same cycle it is detected.
REQ-026 The bit counter is 4 bits, reset at each byte boundary; it never wraps within a byte.

Reset
REQ-027 On reset: state=IDLE, o_sda_oe=0, o_dac_value=RESET_CODE, o_pd=2'b00, o_update=0, o_busy=0; synchronizers load 1 (idle bus).
REQ-028 Reset mid-transfer SHALL abandon the transfer; the block rejoins only at the next START.

Structure
REQ-029 The state encoding, the fast-mode command value 2'b00 and the default DEV_ADDR SHALL live in shared package mcp4725_pkg, which the existing DAC driver also uses.
REQ-030 Synchronizer plus START/STOP/edge detection SHALL be one sub-module, i2c_line_sync, instantiated once.

Verification
REQ-031 Write 8'hC2, 8'h07, 8'hFF, then STOP -> ACK on all three bytes; o_dac_value=12'h7FF, o_pd=2'b00; one o_update pulse.
REQ-032 Write 8'hC4 (wrong address) and two data bytes -> no ACK; outputs unchanged; no o_update; o_busy high until STOP.
REQ-033 Address 8'hC3 (read) -> NACK; IGNORE until STOP; outputs unchanged.
REQ-034 8'hC2, 8'h2A, 8'h55, 8'h0F, 8'hF0, then STOP -> two o_update pulses; final o_dac_value=12'hFF0, o_pd=2'b00 (first pair gives 12'hA55 with o_pd=2'b10).
REQ-035 8'hC2, 8'h03, then repeated START, 8'hC2, 8'h01, 8'h23, STOP -> a single update to 12'h123.
REQ-036 Assert reset during the LO_BYTE bits -> SDA released, o_dac_value=12'h800, no o_update; the next full transfer completes normally.
